mem_read_arbiter: RTL and testbench
===================================

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  DATA_WIDTH, 32, memory word width
  CODE_WIDTH, 8, instruction code width
  NUM_KEY_VAL, 12, entries per memory
  NUM_REQ, 4, decoder requesters (>=2)
  MEM_DELAY, 2, memory read latency in cycles (>=1)
  Derived: ADDR_W = $clog2(NUM_KEY_VAL); IDX_W = $clog2(NUM_REQ).
REQ-002 Ports, one per line: name, direction, width, meaning:
  clock  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  req  in  NUM_REQ  per-requester read request
  req_code  in  NUM_REQ*CODE_WIDTH  per-requester code, slice i = bits [i*CODE_WIDTH +: CODE_WIDTH]
  gnt  out  NUM_REQ  one-hot, one-cycle accept pulse
  rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
  rsp_data  out  DATA_WIDTH  response word
  rsp_err  out  1  address out of range, valid with rsp_valid
  busy  out  1  transaction in flight
  mem_key_val_addr  out  ADDR_W  key-value memory read address
  mem_state_var_addr  out  ADDR_W  state-variable memory read address
  mem_key_val_data_out  in  DATA_WIDTH  key-value read data
  mem_state_var_data_out  in  DATA_WIDTH  state-variable read data
REQ-003 Single clock domain: clock; reset is synchronous and active-high.

Function
REQ-004 Code fields: select = code[CODE_WIDTH-3] (0 key-value, 1 state-variable); address = code[ADDR_W-1:0].
REQ-005 FSM states: IDLE, WAIT; one transaction in flight at a time.
REQ-006 IDLE, edge with any req high: pick winner w, latch code, drive both address ports with the address, gnt[w]=1 for one cycle, busy=1, counter=MEM_DELAY-1, go WAIT.
REQ-007 IDLE, no req: stay IDLE; gnt, rsp_valid = 0.
REQ-008 WAIT, counter!=0: decrement, hold addresses stable.
REQ-009 WAIT, counter==0: capture selected memory data into rsp_data, rsp_valid[w]=1 for one cycle, busy=0, go IDLE.
REQ-010 Latency: req sampled at edge T -> gnt high in cycle T+1, memory data sampled at edge T+MEM_DELAY, rsp_valid high in cycle T+MEM_DELAY+1; next grant no earlier than edge T+MEM_DELAY+1.
REQ-011 Requester holds req and req_code stable until gnt; code sampled only at the grant edge; req dropped before grant = withdrawn, no response.
REQ-012 Address >= NUM_KEY_VAL: same latency, rsp_data=0, rsp_err=1; otherwise rsp_err=0.
REQ-013 rsp_data holds its last value between responses; gnt and rsp_valid are never high for two requesters at once.
REQ-014 A requester whose req stays high at its own rsp_valid cycle is eligible again in the next IDLE arbitration.

Reset
REQ-015 Reset forces IDLE; gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, both addresses=0, counter=MEM_DELAY-1, priority pointer=NUM_REQ-1.
REQ-016 Reset mid-transaction abandons it: no rsp_valid is issued for it.

Configuration
REQ-017 Macro ARB_ROUND_ROBIN_EN defined: round-robin; the search starts at pointer+1 modulo NUM_REQ, and the pointer updates to w on each grant.
REQ-018 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register.

Verification
REQ-019 MEM_DELAY=2, req[1] with code 8'h23 (select 1, addr 3), state memory returns 32'hCAFE0003 -> gnt[1] in cycle T+1, rsp_valid[1] in cycle T+3, rsp_data=32'hCAFE0003, rsp_err=0.
REQ-020 req[0] with code 8'h05, key memory entry 5 = 32'h00000055 -> rsp_data=32'h55, key address=5.
REQ-021 Code 8'h0E (addr 14 >= 12) -> rsp_valid after the same latency, rsp_data=0, rsp_err=1.
REQ-022 req=4'b1111 held for 4 transactions -> with ARB_ROUND_ROBIN_EN, grant order 0,1,2,3; without it, 0,0,0,0.
REQ-023 Reset asserted one cycle after gnt[2] -> no rsp_valid; busy=0; next req[2] is served normally.
REQ-024 req[3] dropped before its grant while req[0] is in flight -> no gnt[3] and no rsp_valid[3].

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one key-value / state-variable memory read port among NUM_REQ decoders.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module mem_read_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int CODE_WIDTH  = 8,
  parameter int NUM_KEY_VAL = 12,
  parameter int NUM_REQ     = 4,
  parameter int MEM_DELAY   = 2,
  localparam int ADDR_W = $clog2(NUM_KEY_VAL),
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*CODE_WIDTH-1:0] req_code,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [ADDR_W-1:0]             mem_key_val_addr,
  output logic [ADDR_W-1:0]             mem_state_var_addr,
  input  logic [DATA_WIDTH-1:0]         mem_key_val_data_out,
  input  logic [DATA_WIDTH-1:0]         mem_state_var_data_out
);

  // Handshake: a requester raises req[i] with a stable code and holds both until the
  // one-cycle gnt[i] pulse; the code is sampled only on the granting edge, dropping req
  // earlier withdraws it, and each grant is answered by exactly one rsp_valid[i] pulse.

  localparam int CNT_W = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(MEM_DELAY - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_KEY_VAL);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Complete FSM state in one struct so checkers can bind to fsm_q directly.
  typedef struct packed {
    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   win;
  } fsm_t;

  localparam fsm_t FSM_RESET = '{state: ST_IDLE, cnt: CNT_INIT, win: '0};

  fsm_t                  fsm_q, fsm_d;
  logic                  sel_q, sel_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [CODE_WIDTH-1:0] codes [NUM_REQ];
  logic [CODE_WIDTH-1:0] win_code;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_found;
  logic                  addr_oor;
  logic                  unused_code_bits;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_code
    assign codes[g] = req_code[g*CODE_WIDTH +: CODE_WIDTH];
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] rr_idx;

  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req[IDX_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`endif

  assign win_code         = codes[win_idx];
  assign unused_code_bits = ^win_code;
  assign addr_oor         = ({1'b0, addr_q} >= ADDR_LIMIT);

  always_comb begin
    fsm_d       = fsm_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    unique case (fsm_q.state)
      ST_IDLE: begin
        if (win_found) begin
          fsm_d.state    = ST_WAIT;
          fsm_d.cnt      = CNT_INIT;
          fsm_d.win      = win_idx;
          sel_d          = win_code[CODE_WIDTH-3];
          addr_d         = win_code[ADDR_W-1:0];
          gnt_d[win_idx] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d          = win_idx;
`endif
        end
      end
      ST_WAIT: begin
        if (fsm_q.cnt != '0) begin
          fsm_d.cnt = fsm_q.cnt - CNT_W'(1);
        end else begin
          // Memory data is valid on this edge; out-of-range addresses answer zero with an error.
          fsm_d.state                = ST_IDLE;
          fsm_d.cnt                  = CNT_INIT;
          rsp_valid_d[fsm_q.win]     = 1'b1;
          rsp_err_d                  = addr_oor;
          if (addr_oor) begin
            rsp_data_d = '0;
          end else if (sel_q) begin
            rsp_data_d = mem_state_var_data_out;
          end else begin
            rsp_data_d = mem_key_val_data_out;
          end
        end
      end
      default: begin
        fsm_d = FSM_RESET;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= FSM_RESET;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      fsm_q       <= fsm_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt                = gnt_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_err            = rsp_err_q;
  assign busy               = (fsm_q.state == ST_WAIT);
  assign mem_key_val_addr   = addr_q;
  assign mem_state_var_addr = addr_q;

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt_q));
  a_rsp_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(rsp_valid_q));
  a_gnt_busy:   assert property (@(posedge clock) disable iff (reset) (gnt_q != '0) |-> busy);
  a_rsp_idle:   assert property (@(posedge clock) disable iff (reset) (rsp_valid_q != '0) |-> !busy);
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed cases plus random requesters, checked by a timestamp-based model.
module tb_mem_read_arbiter;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int NKV = 12;
  localparam int NR  = 4;
  localparam int MD  = 2;
  localparam int AW  = $clog2(NKV);
  localparam int RSP_W = 8 + 1 + DW + 32;
  localparam int GNT_W = 8 + 32;
  localparam logic [NR-1:0] ONE = 1;

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*CW-1:0] req_code = '0;
  logic [NR-1:0]    gnt, rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err, busy;
  logic [AW-1:0]    mem_key_val_addr, mem_state_var_addr;
  logic [DW-1:0]    mem_key_val_data_out, mem_state_var_data_out;
  logic [DW-1:0]    kv_mem [16];
  logic [DW-1:0]    st_mem [16];

  always #5 clock = ~clock;

  assign mem_key_val_data_out   = kv_mem[mem_key_val_addr];
  assign mem_state_var_data_out = st_mem[mem_state_var_addr];

  mem_read_arbiter #(
    .DATA_WIDTH(DW), .CODE_WIDTH(CW), .NUM_KEY_VAL(NKV), .NUM_REQ(NR), .MEM_DELAY(MD)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_code(req_code),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mem_key_val_addr(mem_key_val_addr), .mem_state_var_addr(mem_state_var_addr),
    .mem_key_val_data_out(mem_key_val_data_out), .mem_state_var_data_out(mem_state_var_data_out)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic mon_en = 1'b0;
  logic [RSP_W-1:0] exp_q[$];
  logic [GNT_W-1:0] gnt_exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: the arbiter is free again MD+1 edges after a grant; a grant at edge e
  // shows gnt after e and the response after edge e+MD. Reset drops everything outstanding.
  int e          = 0;
  int next_free  = 0;
  int busy_until = 0;
  int cur_addr   = 0;
  int ptr        = NR - 1;
  logic [DW-1:0] last_data = '0;
  int m_w, m_a;
  logic [CW-1:0] m_c;
  logic [DW-1:0] m_d;
  logic m_err;

  function automatic int pick(input logic [NR-1:0] r, input int p);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
`else
    for (int k = 0; k < NR; k++) if (r[k]) return k + 0 * p;
`endif
    return -1;
  endfunction

  always @(posedge clock) begin
    e++;
    if (reset) begin
      exp_q.delete();
      gnt_exp_q.delete();
      next_free  = e + 1;
      busy_until = e;
      ptr        = NR - 1;
      last_data  = '0;
    end else if (e >= next_free && req != '0) begin
      m_w   = pick(req, ptr);
      m_c   = req_code[m_w*CW +: CW];
      m_a   = int'(m_c[AW-1:0]);
      m_err = (m_a >= NKV);
      m_d   = m_err ? '0 : (m_c[CW-3] ? st_mem[m_a] : kv_mem[m_a]);
      gnt_exp_q.push_back({8'(m_w), 32'(e)});
      exp_q.push_back({8'(m_w), m_err, m_d, 32'(e + MD)});
      next_free  = e + MD + 1;
      busy_until = e + MD;
      cur_addr   = m_a;
      ptr        = m_w;
    end
  end

  // ---------------- monitor ----------------
  logic [GNT_W-1:0] mg;
  logic [RSP_W-1:0] mr;

  always @(negedge clock) begin
    if (mon_en) begin
      chk("gnt_onehot", 64'($onehot0(gnt)), 64'(1));
      if (gnt != '0) begin
        if (gnt_exp_q.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'(0));
        else begin
          mg = gnt_exp_q.pop_front();
          chk("gnt_index", 64'(gnt), 64'(ONE << mg[39:32]));
          chk("gnt_cycle", 64'(e), 64'(mg[31:0]));
        end
      end else if (gnt_exp_q.size() != 0 && int'(gnt_exp_q[0][31:0]) <= e) begin
        mg = gnt_exp_q.pop_front();
        chk("gnt_missing", 64'(gnt), 64'(ONE << mg[39:32]));
      end

      chk("rsp_onehot", 64'($onehot0(rsp_valid)), 64'(1));
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        else begin
          mr = exp_q.pop_front();
          chk("rsp_index", 64'(rsp_valid), 64'(ONE << mr[72:65]));
          chk("rsp_cycle", 64'(e), 64'(mr[31:0]));
          chk("rsp_data", 64'(rsp_data), 64'(mr[63:32]));
          chk("rsp_err", 64'(rsp_err), 64'(mr[64]));
          last_data = mr[63:32];
        end
      end else begin
        if (exp_q.size() != 0 && int'(exp_q[0][31:0]) <= e) begin
          mr = exp_q.pop_front();
          chk("rsp_missing", 64'(rsp_valid), 64'(ONE << mr[72:65]));
        end
        chk("rsp_data_hold", 64'(rsp_data), 64'(last_data));
      end

      chk("busy", 64'(busy), 64'(e < busy_until));
      if (e < busy_until) begin
        chk("key_addr", 64'(mem_key_val_addr), 64'(cur_addr));
        chk("state_addr", 64'(mem_state_var_addr), 64'(cur_addr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int i, input logic [CW-1:0] c);
    req[i] = 1'b1;
    req_code[i*CW +: CW] = c;
  endtask

  task automatic wait_gnt(input int i);
    bit seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      tick();
      if (gnt[i]) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL wait_gnt%0d: no grant within 30 cycles, grant required", i);
    end
  endtask

  task automatic wait_rsp(input int i, output int cycles);
    bit seen = 0;
    cycles = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      tick();
      cycles++;
      if (rsp_valid[i]) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL wait_rsp%0d: no response within 30 cycles, response required", i);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int lat, cnt, ng, gi;
  int order [4];
  int exp_order [4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      kv_mem[i] = $urandom;
      st_mem[i] = $urandom;
    end
    st_mem[3]  = 32'hCAFE0003;
    kv_mem[5]  = 32'h00000055;
    kv_mem[14] = 32'hDEAD000E;
    st_mem[14] = 32'hBEEF000E;

    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    chk("reset_gnt", 64'(gnt), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    chk("reset_rsp_err", 64'(rsp_err), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_key_addr", 64'(mem_key_val_addr), 64'(0));
    chk("reset_state_addr", 64'(mem_state_var_addr), 64'(0));
    reset = 1'b0;
    repeat (2) tick();

    // State-variable read
    set_req(1, 8'h23);
    wait_gnt(1);
    req[1] = 1'b0;
    wait_rsp(1, lat);
    chk("t_state_latency", 64'(lat), 64'(MD));
    chk("t_state_data", 64'(rsp_data), 64'(32'hCAFE0003));
    chk("t_state_err", 64'(rsp_err), 64'(0));
    repeat (2) tick();

    // Key-value read
    set_req(0, 8'h05);
    wait_gnt(0);
    req[0] = 1'b0;
    chk("t_key_addr", 64'(mem_key_val_addr), 64'(5));
    wait_rsp(0, lat);
    chk("t_key_latency", 64'(lat), 64'(MD));
    chk("t_key_data", 64'(rsp_data), 64'(32'h55));
    repeat (2) tick();

    // Out-of-range address
    set_req(2, 8'h0E);
    wait_gnt(2);
    req[2] = 1'b0;
    wait_rsp(2, lat);
    chk("t_oor_latency", 64'(lat), 64'(MD));
    chk("t_oor_data", 64'(rsp_data), 64'(0));
    chk("t_oor_err", 64'(rsp_err), 64'(1));
    repeat (2) tick();

    // All four held high for four transactions, starting from reset
    pulse_reset();
    for (int i = 0; i < NR; i++) set_req(i, CW'($urandom_range(0, 255)));
    ng = 0;
    for (int n = 0; n < 60 && ng < 4; n++) begin
      tick();
      if (gnt != '0) begin
        gi = 0;
        for (int k = 0; k < NR; k++) if (gnt[k]) gi = k;
        order[ng] = gi;
        ng++;
      end
    end
    req = '0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("t_order_count", 64'(ng), 64'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("t_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
    repeat (6) tick();

    // Reset right after a grant abandons the transaction
    set_req(2, 8'h21);
    wait_gnt(2);
    req[2] = 1'b0;
    pulse_reset();
    chk("t_rst_busy", 64'(busy), 64'(0));
    cnt = (rsp_valid != '0) ? 1 : 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (rsp_valid != '0) cnt++;
    end
    chk("t_rst_no_rsp", 64'(cnt), 64'(0));
    set_req(2, 8'h07);
    wait_gnt(2);
    req[2] = 1'b0;
    wait_rsp(2, lat);
    chk("t_rst_next_latency", 64'(lat), 64'(MD));
    chk("t_rst_next_data", 64'(rsp_data), 64'(kv_mem[7]));
    repeat (2) tick();

    // Requester 3 withdraws while requester 0 is in flight
    set_req(0, 8'h02);
    wait_gnt(0);
    req[0] = 1'b0;
    set_req(3, 8'h24);
    tick();
    req[3] = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (gnt[3] || rsp_valid[3]) cnt++;
    end
    chk("t_withdraw_none", 64'(cnt), 64'(0));

    // Random requesters with occasional reset pulses
    for (int n = 0; n < 1500; n++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (gnt[i]) begin
            if ($urandom_range(0, 2) == 0) req_code[i*CW +: CW] = CW'($urandom_range(0, 255));
            else req[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, CW'($urandom_range(0, 255)));
        end
      end
    end
    reset = 1'b0;
    req = '0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
